persp_divide_q16_16: RTL and testbench

PERSP_DIVIDE_Q16_16 -- requirements
Module: persp_divide_q16_16

---
 rtl/persp_divide_q16_16.sv | 155 +++++++++++++++
 tb/tb_persp_divide_q16_16.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/persp_divide_q16_16.sv
// persp_divide_q16_16: clip-space (x,y,z,w) -> NDC and 1/w, Q16.16.
// Clip outcode is built only when `PERSP_OUTCODE_EN is defined.
module persp_divide_q16_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_vec [0:3],
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_ndc [0:2],
   output logic [31:0] out_inv_w,
   output logic        out_degen,
   output logic [5:0]  out_outcode
);

   typedef enum logic [1:0] {IDLE, DIV, MUL, HOLD} state_t;

   state_t             r_state;
   state_t             w_next;
   logic        [31:0] r_vec [0:3];
   logic        [32:0] r_rem;
   logic        [32:0] r_quo;
   logic        [5:0]  r_cnt;
   logic        [31:0] r_ndc [0:2];
   logic        [31:0] r_inv_w;
   logic               r_degen;
   logic               r_valid;

   logic        [32:0] w_w33;
   logic        [32:0] w_absw;
   logic        [33:0] w_rem_sh;
   logic               w_ge;
   logic        [31:0] w_sat;
   logic        [31:0] w_recip;
   logic signed [63:0] w_prod [0:2];
   logic signed [63:0] w_shr [0:2];
   logic        [31:0] w_ndc [0:2];

   assign w_w33  = {r_vec[3][31], r_vec[3]};
   assign w_absw = r_vec[3][31] ? (33'd0 - w_w33) : w_w33;

   // Dividend is 2^32: a single 1 shifted in on the first step.
   assign w_rem_sh = {r_rem, (r_cnt == 6'd0)};
   assign w_ge     = (w_rem_sh >= {1'b0, w_absw});

   assign w_sat   = (r_quo[32:31] != 2'b00) ? 32'h7FFF_FFFF
                                             : r_quo[31:0];
   assign w_recip = r_vec[3][31] ? (32'd0 - w_sat) : w_sat;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_prod[i] = 64'($signed(r_vec[i])) * 64'($signed(w_recip));
         w_shr[i]  = w_prod[i] >>> 16;
         w_ndc[i]  = w_shr[i][31:0];
         if (w_shr[i] > 64'sh0000_0000_7FFF_FFFF)
            w_ndc[i] = 32'h7FFF_FFFF;
         else if (w_shr[i] < 64'shFFFF_FFFF_8000_0000)
            w_ndc[i] = 32'h8000_0000;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_next = DIV;
         DIV:     if (r_cnt == 6'd32) w_next = MUL;
         MUL:     w_next = HOLD;
         HOLD:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_vec[i] <= '0;
         for (int i = 0; i < 3; i++) r_ndc[i] <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_inv_w <= '0;
         r_degen <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_vec <= in_vec;
                  r_rem <= '0;
                  r_quo <= '0;
                  r_cnt <= '0;
               end
            end
            DIV: begin
               // Low bits suffice: the true remainder stays below |w|.
               r_rem <= w_ge ? (w_rem_sh[32:0] - w_absw)
                             : w_rem_sh[32:0];
               r_quo <= {r_quo[31:0], w_ge};
               r_cnt <= r_cnt + 6'd1;
            end
            MUL: begin
               r_ndc   <= w_ndc;
               r_inv_w <= w_recip;
               r_degen <= (r_vec[3] == 32'd0);
               r_valid <= 1'b1;
            end
            HOLD: begin
               if (out_ready) r_valid <= 1'b0;
            end
            default: r_valid <= 1'b0;
         endcase
      end
   end

`ifdef PERSP_OUTCODE_EN
   logic signed [32:0] w_x;
   logic signed [32:0] w_y;
   logic signed [32:0] w_z;
   logic signed [32:0] w_pw;
   logic signed [32:0] w_nw;
   logic        [5:0]  w_oc;
   logic        [5:0]  r_oc;

   // 33-bit so that -w cannot overflow for w = 0x80000000.
   assign w_x  = $signed({r_vec[0][31], r_vec[0]});
   assign w_y  = $signed({r_vec[1][31], r_vec[1]});
   assign w_z  = $signed({r_vec[2][31], r_vec[2]});
   assign w_pw = $signed(w_w33);
   assign w_nw = -w_pw;
   assign w_oc = {w_z > w_pw, w_z < w_nw,
                  w_y > w_pw, w_y < w_nw,
                  w_x > w_pw, w_x < w_nw};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_oc <= '0;
      else if (r_state == MUL)  r_oc <= w_oc;
   end

   assign out_outcode = r_oc;
`else
   assign out_outcode = 6'b0;
`endif

   assign in_ready  = rst_n && (r_state == IDLE);
   assign out_valid = r_valid;
   assign out_ndc   = r_ndc;
   assign out_inv_w = r_inv_w;
   assign out_degen = r_degen;

endmodule

// File: tb/tb_persp_divide_q16_16.sv
// tb_persp_divide_q16_16: directed vectors for persp_divide_q16_16.
// Outcode expectations follow `PERSP_OUTCODE_EN.
module tb_persp_divide_q16_16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_vec [0:3];
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_ndc [0:2];
   logic [31:0] out_inv_w;
   logic        out_degen;
   logic [5:0]  out_outcode;

   int n_chk = 0;
   int n_err = 0;

   persp_divide_q16_16 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_vec      (in_vec),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_ndc     (out_ndc),
      .out_inv_w   (out_inv_w),
      .out_degen   (out_degen),
      .out_outcode (out_outcode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input logic [31:0] w);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
      in_vec[0] = x;
      in_vec[1] = y;
      in_vec[2] = z;
      in_vec[3] = w;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_vec(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [31:0] w,
                          input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] einv,
                          input logic edeg, input logic [5:0] eoc,
                          input int hold);
      int lat;
      logic [5:0] eo;
`ifdef PERSP_OUTCODE_EN
      eo = eoc;
`else
      eo = 6'b0;
`endif
      send(x, y, z, w);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         #1 lat++;
      end
      check("latency", lat, 34);
      check("ndc_x", out_ndc[0], e0);
      check("ndc_y", out_ndc[1], e1);
      check("ndc_z", out_ndc[2], e2);
      check("inv_w", out_inv_w, einv);
      check("degen", out_degen, edeg);
      check("outcode", out_outcode, eo);
      if (hold > 0) begin
         repeat (hold) @(posedge clk);
         #1;
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_ndc_x", out_ndc[0], e0);
         check("hold_ndc_y", out_ndc[1], e1);
         check("hold_inv_w", out_inv_w, einv);
         check("hold_outcode", out_outcode, eo);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("drain_valid", out_valid, 0);
      check("drain_in_ready", in_ready, 1);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 4; i++) in_vec[i] = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_inv_w", out_inv_w, 0);
      check("rst_ndc_x", out_ndc[0], 0);
      check("rst_degen", out_degen, 0);
      check("rst_outcode", out_outcode, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_rst_ready", in_ready, 1);

      run_vec(32'h0002_0000, 0, 0, 32'h0001_0000,
              32'h0002_0000, 0, 0, 32'h0001_0000, 0, 6'h02, 0);
      run_vec(32'h0001_0000, 0, 0, 32'h0002_0000,
              32'h0000_8000, 0, 0, 32'h0000_8000, 0, 6'h00, 10);
      run_vec(32'h0002_0000, 0, 0, 32'hFFFC_0000,
              32'hFFFF_8000, 0, 0, 32'hFFFF_C000, 0, 6'h3F, 0);
      run_vec(32'h0002_0000, 32'hFFFE_0000, 0, 32'h0,
              32'h7FFF_FFFF, 32'h8000_0000, 0, 32'h7FFF_FFFF,
              1, 6'h06, 0);
      run_vec(32'h0003_0000, 0, 0, 32'h0001_0000,
              32'h0003_0000, 0, 0, 32'h0001_0000, 0, 6'h02, 0);
      run_vec(32'h0001_0000, 32'h7FFF_FFFF, 32'hFFFF_8000,
              32'h8000_0000,
              32'hFFFF_FFFE, 32'hFFFF_0000, 32'h0000_0001,
              32'hFFFF_FFFE, 0, 6'h3F, 0);
      run_vec(32'h0000_8000, 0, 0, 32'h0000_0001,
              32'h3FFF_FFFF, 0, 0, 32'h7FFF_FFFF, 0, 6'h02, 0);
      run_vec(32'h0001_0000, 32'hFFFF_0000, 0, 32'h0000_0003,
              32'h5555_5555, 32'hAAAA_AAAB, 0, 32'h5555_5555,
              0, 6'h06, 0);

      // Abort a vertex with reset partway through the divide.
      send(32'h0004_0000, 32'h0001_0000, 0, 32'h0001_0000);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_inv_w", out_inv_w, 0);
      check("abort_ndc_x", out_ndc[0], 0);
      check("abort_outcode", out_outcode, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("abort_ready", in_ready, 1);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      check("abort_no_result", seen, 0);

      run_vec(32'h0002_0000, 0, 0, 32'h0001_0000,
              32'h0002_0000, 0, 0, 32'h0001_0000, 0, 6'h02, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
